// File: rtl/snn_axil_pkg.sv
// snn_axil_pkg: shared constants for the SNN AXI4-Lite register file.
//   Register byte offsets, CTRL/STATUS bit positions, AXI response codes
//   and the coprocessor control FSM state encoding.
package snn_axil_pkg;

   localparam int unsigned ADDR_CTRL     = 'h00;
   localparam int unsigned ADDR_STATUS   = 'h04;
   localparam int unsigned ADDR_RESULT   = 'h08;
   localparam int unsigned ADDR_WR_COUNT = 'h0C;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_CLEAR_BIT  = 2;

   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_DONE_BIT = 1;
   localparam int STAT_RDY_BIT  = 31;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_ARMED,
      ST_RUN
   } ctrl_state_e;

endpackage

// File: rtl/snn_axil_regfile_slot.sv
// axil_skid_slot: one-entry holding slot for an AXI channel beat.
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   valid_i      : producer valid; captured when the slot is empty
//   data_i       : beat payload
//   pop_i        : consumer frees the slot (only asserted while full)
//   ready_o      : slot empty, may accept
//   full_o       : slot holds a beat
//   data_o       : held payload
module axil_skid_slot
   import snn_axil_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             ready_o,
   output logic             full_o,
   output logic [WIDTH-1:0] data_o
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q;

   always_comb begin
      full_d = full_q;
      if (pop_i)
         full_d = 1'b0;
      else if (valid_i && !full_q)
         full_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         full_q <= 1'b0;
      else
         full_q <= full_d;
   end

   // Payload carries no reset: it is only observed while full_q is set.
   always_ff @(posedge clk_i) begin
      if (valid_i && !full_q)
         data_q <= data_i;
   end

   assign ready_o = !full_q;
   assign full_o  = full_q;
   assign data_o  = data_q;

endmodule

// File: rtl/snn_axil_regfile.sv
// snn_axil_regfile: AXI4-Lite slave in front of the SNN coprocessor.
//   ACLK/ARESETN      : clock, asynchronous active-low reset
//   AW/W/B/AR/R       : AXI4-Lite slave channels (PROT ignored)
//   COPROCESSOR_RDY   : SNN idle / result-valid level
//   INFERED_DIGIT     : SNN result, captured at end of a run
//   IMAGE             : pixel array, pixel 0 at lowest address
//   NEW_IMAGE         : one-cycle launch pulse
//   IRQ               : level interrupt, DONE & IRQ_EN
module snn_axil_regfile
   import snn_axil_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 12,
   parameter int IMAGE_SIZE     = 256,
   parameter int PIXEL_BITS     = 8,
   parameter int RESULT_BITS    = 8,
   parameter int IMAGE_BASE     = 'h100
) (
   input  logic                        ACLK,
   input  logic                        ARESETN,
   input  logic [31:0]                 AWADDR,
   input  logic [2:0]                  AWPROT,
   input  logic                        AWVALID,
   output logic                        AWREADY,
   input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
   input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
   input  logic                        WVALID,
   output logic                        WREADY,
   output logic [1:0]                  BRESP,
   output logic                        BVALID,
   input  logic                        BREADY,
   input  logic [31:0]                 ARADDR,
   input  logic [2:0]                  ARPROT,
   input  logic                        ARVALID,
   output logic                        ARREADY,
   output logic [AXI_DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]                  RRESP,
   output logic                        RVALID,
   input  logic                        RREADY,
   input  logic                        COPROCESSOR_RDY,
   input  logic [RESULT_BITS-1:0]      INFERED_DIGIT,
   output logic [PIXEL_BITS-1:0]       IMAGE [IMAGE_SIZE],
   output logic                        NEW_IMAGE,
   output logic                        IRQ
);

   localparam int STRB_W   = AXI_DATA_WIDTH / 8;
   localparam int PPW      = AXI_DATA_WIDTH / PIXEL_BITS;
   localparam int NWORDS   = IMAGE_SIZE / PPW;
   localparam int BPP      = PIXEL_BITS / 8;
   localparam int WORD_LSB = $clog2(STRB_W);
   localparam int IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int IMG_HI   = IMAGE_BASE + NWORDS * STRB_W;

   function automatic logic img_hit(input logic [AXI_ADDR_WIDTH-1:0] a);
      return (32'(a) >= 32'(IMAGE_BASE)) && (32'(a) < 32'(IMG_HI));
   endfunction

   function automatic logic [IDX_W-1:0] img_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
      return IDX_W'((32'(a) - 32'(IMAGE_BASE)) >> WORD_LSB);
   endfunction

   function automatic logic [31:0] reg_off(input logic [AXI_ADDR_WIDTH-1:0] a);
      return 32'(a) & ~32'(STRB_W - 1);
   endfunction

   logic                          aw_full, w_full, commit;
   logic [AXI_ADDR_WIDTH-1:0]     wa;
   logic [AXI_DATA_WIDTH+STRB_W-1:0] w_beat;
   logic [AXI_DATA_WIDTH-1:0]     wd;
   logic [STRB_W-1:0]             ws;
   logic [IDX_W-1:0]              widx;

   ctrl_state_e                   state_q, state_d;
   logic                          irq_en_q, done_q;
   logic [RESULT_BITS-1:0]        result_q;
   logic [AXI_DATA_WIDTH-1:0]     wr_cnt_q;
   logic                          bvalid_q, rvalid_q;
   logic [1:0]                    bresp_q, rresp_q;
   logic [AXI_DATA_WIDTH-1:0]     rdata_q;
   logic [PIXEL_BITS-1:0]         img_q [IMAGE_SIZE];

   logic                          busy, capture, new_image;
   logic [1:0]                    wr_resp;
   logic                          img_we, start_go, clear_go, irqen_we, w1c_done;

   logic                          unused_ok;
   assign unused_ok = ^{AWADDR[31:AXI_ADDR_WIDTH], ARADDR[31:AXI_ADDR_WIDTH], AWPROT, ARPROT};

   axil_skid_slot #(.WIDTH(AXI_ADDR_WIDTH)) u_aw_slot (
      .clk_i   (ACLK),
      .rst_ni  (ARESETN),
      .valid_i (AWVALID),
      .data_i  (AWADDR[AXI_ADDR_WIDTH-1:0]),
      .pop_i   (commit),
      .ready_o (AWREADY),
      .full_o  (aw_full),
      .data_o  (wa)
   );

   axil_skid_slot #(.WIDTH(AXI_DATA_WIDTH + STRB_W)) u_w_slot (
      .clk_i   (ACLK),
      .rst_ni  (ARESETN),
      .valid_i (WVALID),
      .data_i  ({WSTRB, WDATA}),
      .pop_i   (commit),
      .ready_o (WREADY),
      .full_o  (w_full),
      .data_o  (w_beat)
   );

   assign wd     = w_beat[AXI_DATA_WIDTH-1:0];
   assign ws     = w_beat[AXI_DATA_WIDTH +: STRB_W];
   assign widx   = img_idx(wa);
   assign busy   = (state_q != ST_IDLE);
   // A held B response blocks the next commit until the master takes it.
   assign commit = aw_full && w_full && (!bvalid_q || BREADY);

   // Write decode: every side effect is qualified by commit.
   always_comb begin
      wr_resp  = RESP_OKAY;
      img_we   = 1'b0;
      start_go = 1'b0;
      clear_go = 1'b0;
      irqen_we = 1'b0;
      w1c_done = 1'b0;
      if (img_hit(wa)) begin
         if (busy) wr_resp = RESP_SLVERR;
         else      img_we  = commit;
      end else begin
         case (reg_off(wa))
            ADDR_CTRL: begin
               if (ws[0]) begin
                  if (busy && (wd[CTRL_START_BIT] || wd[CTRL_CLEAR_BIT])) begin
                     wr_resp = RESP_SLVERR;
                  end else begin
                     start_go = commit && wd[CTRL_START_BIT];
                     clear_go = commit && wd[CTRL_CLEAR_BIT];
                     irqen_we = commit;
                  end
               end
            end
            ADDR_STATUS:   w1c_done = commit && ws[0] && wd[STAT_DONE_BIT];
            ADDR_RESULT:   ;
            ADDR_WR_COUNT: ;
            default:       wr_resp = RESP_SLVERR;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      new_image = 1'b0;
      capture   = 1'b0;
      unique case (state_q)
         ST_IDLE:   if (start_go) state_d = ST_LAUNCH;
         ST_LAUNCH: begin
            new_image = 1'b1;
            state_d   = ST_ARMED;
         end
         ST_ARMED:  if (!COPROCESSOR_RDY) state_d = ST_RUN;
         ST_RUN: begin
            if (COPROCESSOR_RDY) begin
               capture = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q  <= ST_IDLE;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         wr_cnt_q <= '0;
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         if (irqen_we) irq_en_q <= wd[CTRL_IRQ_EN_BIT];
         // Capture has priority so a completion racing a W1C is not lost.
         if (capture)                    done_q <= 1'b1;
         else if (w1c_done || start_go)  done_q <= 1'b0;
         if (capture) result_q <= INFERED_DIGIT;
         if (start_go || clear_go)        wr_cnt_q <= '0;
         else if (img_we && !(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + 1'b1;
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
         end else if (BREADY) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int k = 0; k < IMAGE_SIZE; k++) img_q[k] <= '0;
      end else if (clear_go) begin
         for (int k = 0; k < IMAGE_SIZE; k++) img_q[k] <= '0;
      end else if (img_we) begin
         for (int k = 0; k < IMAGE_SIZE; k++) begin
            if (widx == IDX_W'(k / PPW)) begin
               for (int b = 0; b < BPP; b++) begin
                  if (ws[(k % PPW) * BPP + b])
                     img_q[k][b*8 +: 8] <= wd[(k % PPW) * PIXEL_BITS + b*8 +: 8];
               end
            end
         end
      end
   end

   logic [AXI_ADDR_WIDTH-1:0] ra;
   logic [IDX_W-1:0]          ridx;
   logic [AXI_DATA_WIDTH-1:0] rd_word;
   logic [1:0]                rd_resp;

   assign ra   = ARADDR[AXI_ADDR_WIDTH-1:0];
   assign ridx = img_idx(ra);

   always_comb begin
      rd_word = '0;
      rd_resp = RESP_OKAY;
      if (img_hit(ra)) begin
         for (int k = 0; k < IMAGE_SIZE; k++) begin
            if (ridx == IDX_W'(k / PPW))
               rd_word[(k % PPW) * PIXEL_BITS +: PIXEL_BITS] = img_q[k];
         end
      end else begin
         case (reg_off(ra))
            ADDR_CTRL:     rd_word[CTRL_IRQ_EN_BIT] = irq_en_q;
            ADDR_STATUS: begin
               rd_word[STAT_BUSY_BIT] = busy;
               rd_word[STAT_DONE_BIT] = done_q;
               rd_word[STAT_RDY_BIT]  = COPROCESSOR_RDY;
            end
            ADDR_RESULT:   rd_word = AXI_DATA_WIDTH'(result_q);
            ADDR_WR_COUNT: rd_word = wr_cnt_q;
            default:       rd_resp = RESP_SLVERR;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else if (ARVALID && !rvalid_q) begin
         rvalid_q <= 1'b1;
         rresp_q  <= rd_resp;
         rdata_q  <= rd_word;
      end else if (RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   assign ARREADY   = !rvalid_q;
   assign RVALID    = rvalid_q;
   assign RRESP     = rresp_q;
   assign RDATA     = rdata_q;
   assign BVALID    = bvalid_q;
   assign BRESP     = bresp_q;
   assign IMAGE     = img_q;
   assign NEW_IMAGE = new_image;
   assign IRQ       = done_q && irq_en_q;

endmodule

// File: tb/tb_snn_axil_regfile.sv
module tb_snn_axil_regfile;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [31:0] AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID, AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID, WREADY;
   logic [1:0]  BRESP;
   logic        BVALID, BREADY;
   logic [31:0] ARADDR;
   logic [2:0]  ARPROT;
   logic        ARVALID, ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID, RREADY;
   logic        COPROCESSOR_RDY;
   logic [7:0]  INFERED_DIGIT;
   logic [7:0]  IMAGE [256];
   logic        NEW_IMAGE, IRQ;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   always #5 ACLK = ~ACLK;

   always @(negedge ACLK) if (NEW_IMAGE) pulses++;

   snn_axil_regfile dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
      .COPROCESSOR_RDY(COPROCESSOR_RDY), .INFERED_DIGIT(INFERED_DIGIT),
      .IMAGE(IMAGE), .NEW_IMAGE(NEW_IMAGE), .IRQ(IRQ)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      logic aw_go, w_go;
      AWADDR = a; WDATA = d; WSTRB = s;
      AWVALID = 1'b1; WVALID = 1'b1;
      for (int n = 0; n < 20 && (AWVALID || WVALID); n++) begin
         aw_go = AWVALID && AWREADY;
         w_go  = WVALID && WREADY;
         tick();
         if (aw_go) AWVALID = 1'b0;
         if (w_go)  WVALID  = 1'b0;
      end
      AWVALID = 1'b0; WVALID = 1'b0;
      for (int n = 0; n < 20 && !BVALID; n++) tick();
      chk("wr_bvalid", 32'(BVALID), 1);
      resp = BRESP;
      tick();
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      ARADDR = a; ARVALID = 1'b1;
      for (int n = 0; n < 20 && !ARREADY; n++) tick();
      tick();
      ARVALID = 1'b0;
      for (int n = 0; n < 20 && !RVALID; n++) tick();
      chk("rd_rvalid", 32'(RVALID), 1);
      d = RDATA; resp = RRESP;
      tick();
   endtask

   logic [1:0]  r;
   logic [31:0] d;

   initial begin
      ARESETN = 1'b0;
      AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
      ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b1;
      COPROCESSOR_RDY = 1'b1; INFERED_DIGIT = 8'd7;
      repeat (3) tick();

      // reset state
      chk("rst_awready", 32'(AWREADY), 1);
      chk("rst_wready",  32'(WREADY), 1);
      chk("rst_arready", 32'(ARREADY), 1);
      chk("rst_bvalid",  32'(BVALID), 0);
      chk("rst_rvalid",  32'(RVALID), 0);
      chk("rst_rdata",   RDATA, 0);
      chk("rst_newimg",  32'(NEW_IMAGE), 0);
      chk("rst_irq",     32'(IRQ), 0);
      chk("rst_pix0",    32'(IMAGE[0]), 0);
      ARESETN = 1'b1;
      tick();

      // full-word image write and read-back
      axi_write(32'h100, 32'h04030201, 4'hF, r);
      chk("img_wr_bresp", 32'(r), 0);
      chk("img_pix0", 32'(IMAGE[0]), 32'h01);
      chk("img_pix1", 32'(IMAGE[1]), 32'h02);
      chk("img_pix2", 32'(IMAGE[2]), 32'h03);
      chk("img_pix3", 32'(IMAGE[3]), 32'h04);
      axi_read(32'h100, d, r);
      chk("img_rd_data", d, 32'h04030201);
      chk("img_rd_resp", 32'(r), 0);

      // W three cycles before AW, single-byte strobe
      WDATA = 32'h0000AB00; WSTRB = 4'h2; WVALID = 1'b1;
      tick();
      WVALID = 1'b0;
      chk("wfirst_wready_full", 32'(WREADY), 0);
      repeat (3) tick();
      AWADDR = 32'h100; AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      chk("wfirst_bvalid_early", 32'(BVALID), 0);
      tick();
      chk("wfirst_bvalid", 32'(BVALID), 1);
      chk("wfirst_bresp", 32'(BRESP), 0);
      tick();
      chk("wfirst_pix0", 32'(IMAGE[0]), 32'h01);
      chk("wfirst_pix1", 32'(IMAGE[1]), 32'hAB);
      chk("wfirst_pix2", 32'(IMAGE[2]), 32'h03);

      // unmapped addresses
      axi_write(32'h300, 32'hFFFFFFFF, 4'hF, r);
      chk("bad_wr_resp", 32'(r), 2);
      axi_read(32'h010, d, r);
      chk("bad_rd_resp", 32'(r), 2);
      chk("bad_rd_data", d, 0);
      axi_read(32'h100, d, r);
      chk("img_unchanged", d, 32'h0403AB01);
      axi_read(32'h00C, d, r);
      chk("wr_count_2", d, 2);

      // IRQ enable, then launch
      axi_write(32'h000, 32'h2, 4'hF, r);
      axi_read(32'h000, d, r);
      chk("ctrl_irq_en", d, 32'h2);
      axi_write(32'h000, 32'h3, 4'hF, r);
      chk("start_bresp", 32'(r), 0);
      axi_read(32'h004, d, r);
      chk("status_armed", d, 32'h80000001);
      axi_write(32'h104, 32'hFFFFFFFF, 4'hF, r);
      chk("busy_img_wr", 32'(r), 2);
      axi_read(32'h00C, d, r);
      chk("wr_count_launch", d, 0);
      COPROCESSOR_RDY = 1'b0;
      repeat (2) tick();
      axi_read(32'h004, d, r);
      chk("status_run", d, 32'h00000001);
      chk("irq_run", 32'(IRQ), 0);
      COPROCESSOR_RDY = 1'b1;
      tick();
      chk("irq_done", 32'(IRQ), 1);
      axi_read(32'h004, d, r);
      chk("status_done", d, 32'h80000002);
      axi_read(32'h008, d, r);
      chk("result", d, 7);
      chk("newimg_pulses", 32'(pulses), 1);
      chk("pix4_after_busy_wr", 32'(IMAGE[4]), 0);
      axi_write(32'h004, 32'h2, 4'hF, r);
      chk("w1c_irq", 32'(IRQ), 0);
      axi_read(32'h004, d, r);
      chk("status_w1c", d, 32'h80000000);

      // BREADY held low blocks the next commit
      BREADY = 1'b0;
      AWADDR = 32'h104; WDATA = 32'h11111111; WSTRB = 4'hF;
      AWVALID = 1'b1; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      tick();
      chk("bp_bvalid1", 32'(BVALID), 1);
      chk("bp_pix4", 32'(IMAGE[4]), 32'h11);
      AWADDR = 32'h108; WDATA = 32'h22222222;
      AWVALID = 1'b1; WVALID = 1'b1;
      tick();
      AWVALID = 1'b0; WVALID = 1'b0;
      repeat (5) tick();
      chk("bp_bvalid_held", 32'(BVALID), 1);
      chk("bp_awready", 32'(AWREADY), 0);
      chk("bp_pix8_blocked", 32'(IMAGE[8]), 0);
      BREADY = 1'b1;
      tick();
      chk("bp_bvalid2", 32'(BVALID), 1);
      chk("bp_pix8", 32'(IMAGE[8]), 32'h22);
      tick();
      chk("bp_bvalid_done", 32'(BVALID), 0);

      // asynchronous reset in the middle of a run
      axi_write(32'h000, 32'h3, 4'hF, r);
      COPROCESSOR_RDY = 1'b0;
      repeat (3) tick();
      #2;
      ARESETN = 1'b0;
      #1;
      chk("arst_irq", 32'(IRQ), 0);
      chk("arst_pix0", 32'(IMAGE[0]), 0);
      chk("arst_pix4", 32'(IMAGE[4]), 0);
      chk("arst_newimg", 32'(NEW_IMAGE), 0);
      COPROCESSOR_RDY = 1'b1;
      tick();
      ARESETN = 1'b1;
      tick();
      axi_read(32'h004, d, r);
      chk("arst_status", d, 32'h80000000);
      axi_read(32'h000, d, r);
      chk("arst_ctrl", d, 0);

      // CLEAR wipes pixels and WR_COUNT
      axi_write(32'h100, 32'hDEADBEEF, 4'hF, r);
      chk("pre_clear_pix0", 32'(IMAGE[0]), 32'hEF);
      axi_write(32'h000, 32'h4, 4'hF, r);
      chk("clear_bresp", 32'(r), 0);
      chk("clear_pix0", 32'(IMAGE[0]), 0);
      chk("clear_pix3", 32'(IMAGE[3]), 0);
      axi_read(32'h00C, d, r);
      chk("clear_wr_count", d, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
